muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide sequencer attached to the execute stage. It accepts one M-extension operation per request using the forwarded rs1/rs2 values, holds the pipeline through a 32-step shift-add or restoring-divide loop, and returns the 32-bit result with a one-cycle-qualified handshake. The execute stage muxes `result` into `aluout` when `done` is high. The pipeline stall logic ORs `busy` into the global stall.

---
 rtl/muldiv_sequencer.sv | 98 +++++++++
 tb/tb_muldiv_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit that stalls EX for 32 steps
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_n;
    logic [4:0]        cnt;
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   hi, lo, b;
    logic              accept, s1, s2, n1, n2, by0, ovf, special, ge;
    logic [XLEN-1:0]   m1, m2, spec_res, hi_n, lo_n, sel, sel_s, fin;
    logic [XLEN:0]     sum, sh, diff;
    logic [2*XLEN-1:0] prod, prod_s;

    // Operand conditioning: signedness per op, magnitudes, and the early-out cases
    always_comb begin
        accept   = state == IDLE && start && !flush;
        s1       = funct3[2] ? !funct3[0] : funct3[0] ^ funct3[1];
        s2       = funct3[2] ? !funct3[0] : funct3[1:0] == 2'b01;
        n1       = s1 && rs1_data[XLEN-1];
        n2       = s2 && rs2_data[XLEN-1];
        m1       = n1 ? -rs1_data : rs1_data;
        m2       = n2 ? -rs2_data : rs2_data;
        by0      = funct3[2] && rs2_data == '0;
        ovf      = funct3[2] && !funct3[0] && rs1_data == MIN_NEG && rs2_data == '1;
        special  = by0 || ovf;
        spec_res = by0 ? (funct3[1] ? rs1_data : '1) : (funct3[1] ? '0 : MIN_NEG);
    end

    // One shift-add or restoring-subtract step, plus sign fix-up for the final step
    always_comb begin
        sum    = {1'b0, hi} + {1'b0, lo[0] ? b : '0};
        sh     = {hi, lo[XLEN-1]};
        diff   = sh - {1'b0, b};
        ge     = !diff[XLEN];
        hi_n   = op[2] ? (ge ? diff[XLEN-1:0] : sh[XLEN-1:0]) : sum[XLEN:1];
        lo_n   = op[2] ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
        prod   = {hi_n, lo_n};
        prod_s = neg ? -prod : prod;
        sel    = op[1] ? hi_n : lo_n;
        sel_s  = neg ? -sel : sel;
        fin    = op[2] ? sel_s : (op[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
    end

    // Next state and handshake outputs; flush wins over everything
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (special ? DONE : CALC) : IDLE;
            CALC:    state_n = cnt == 5'd31 ? DONE : CALC;
            DONE:    state_n = ex_stall ? DONE : IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
        busy = !rst && (accept || state == CALC);
        done = state == DONE;
    end

    // State, operand latches, iteration registers and the result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op  <= funct3;
                neg <= n1 ^ (n2 && !(funct3[2] && funct3[1]));
                cnt <= '0;
                hi  <= '0;
                lo  <= m1;
                b   <= m2;
                if (special) result <= spec_res;
            end else if (state == CALC) begin
                cnt <= cnt + 5'd1;
                hi  <= hi_n;
                lo  <= lo_n;
                if (cnt == 5'd31) result <= fin;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed table, corner sequences and randomized ops against an arithmetic model
module tb_muldiv_sequencer;
    logic        clk = 0, rst, start, ex_stall, flush, busy, done;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, result;
    int vectors = 0, errors = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[16];

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_stall(ex_stall),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = int'(a);
        ib = int'(b);
        if (f == 3'b000) begin p = ua * ub; return p[31:0]; end
        if (f == 3'b001) begin p = sa * sb; return p[63:32]; end
        if (f == 3'b010) begin p = sa * ub; return p[63:32]; end
        if (f == 3'b011) begin p = ua * ub; return p[63:32]; end
        if (b == 0) return f[1] ? a : 32'hFFFFFFFF;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : 32'h80000000;
        if (f == 3'b100) return ia / ib;
        if (f == 3'b101) return a / b;
        if (f == 3'b110) return ia % ib;
        return a % b;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge after done falls
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm);
        int k, lat;
        logic bad;
        lat = is_special(f, a, b) ? 1 : 33;
        start = 1; funct3 = f; rs1_data = a; rs2_data = b;
        #1 chk({nm, "_busy_accept"}, busy, 1);
        @(negedge clk);
        start = 0; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        k = 1; bad = 0;
        while (!done && k < 40) begin
            if (!busy) bad = 1;
            @(negedge clk);
            k++;
        end
        chk({nm, "_latency"}, k, lat);
        chk({nm, "_busy_calc"}, bad, 0);
        chk({nm, "_result"}, result, exp);
        chk({nm, "_busy_done"}, busy, 0);
        @(negedge clk);
        chk({nm, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int k;
        logic seen;
        tbl[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        tbl[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[2]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
        tbl[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        tbl[4]  = '{3'b100, 32'd7,        32'd0,        32'hFFFFFFFF};
        tbl[5]  = '{3'b111, 32'd7,        32'd0,        32'd7};
        tbl[6]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        tbl[7]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0};
        tbl[8]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        tbl[9]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        tbl[10] = '{3'b101, 32'd100,      32'd7,        32'd14};
        tbl[11] = '{3'b111, 32'd100,      32'd7,        32'd2};
        tbl[12] = '{3'b110, 32'd7,        32'd0,        32'd7};
        tbl[13] = '{3'b101, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF};
        tbl[14] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        tbl[15] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1};

        rst = 1; start = 1; funct3 = 3'b000; rs1_data = 5; rs2_data = 5; ex_stall = 0; flush = 0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        rst = 0; start = 0;
        @(negedge clk);
        chk("post_reset_done", done, 0);
        chk("post_reset_busy", busy, 0);

        for (int i = 0; i < 16; i++)
            do_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("tbl%0d", i));

        // flush in the middle of a divide, then restart right away
        start = 1; funct3 = 3'b100; rs1_data = 100; rs2_data = 7;
        @(negedge clk);
        start = 0; seen = 0;
        for (int i = 1; i < 10; i++) begin
            if (done) seen = 1;
            @(negedge clk);
        end
        flush = 1;
        #1 chk("flush_busy_before", busy, 1);
        @(negedge clk);
        flush = 0;
        chk("flush_no_done", seen | done, 0);
        chk("flush_busy_after", busy, 0);
        do_op(3'b101, 32'd9, 32'd3, 32'd3, "divu_after_flush");

        // flush coincident with start: never accepted
        start = 1; flush = 1; funct3 = 3'b100; rs1_data = 50; rs2_data = 5;
        #1 chk("flush_start_busy", busy, 0);
        @(negedge clk);
        start = 0; flush = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen = 1;
            @(negedge clk);
        end
        chk("flush_start_idle", seen, 0);

        // ex_stall holds DONE with start still asserted
        ex_stall = 1; start = 1; funct3 = 3'b000; rs1_data = 3; rs2_data = 5;
        @(negedge clk);
        rs1_data = $urandom; rs2_data = $urandom;
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("stall_latency", k, 33);
        chk("stall_result0", result, 15);
        for (int j = 1; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("stall_done%0d", j), done, 1);
            chk($sformatf("stall_result%0d", j), result, 15);
            chk($sformatf("stall_busy%0d", j), busy, 0);
        end
        ex_stall = 0; start = 0;
        @(negedge clk);
        chk("stall_release_done", done, 0);
        chk("stall_release_busy", busy, 0);

        // reset during CALC aborts with all outputs cleared
        start = 1; funct3 = 3'b011; rs1_data = 32'hFFFFFFFF; rs2_data = 32'hFFFFFFFF;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("rst_calc_busy", busy, 0);
        chk("rst_calc_done", done, 0);
        chk("rst_calc_result", result, 0);
        rst = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen = 1;
            @(negedge clk);
        end
        chk("rst_calc_quiet", seen, 0);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            do_op(f, a, b, model(f, a, b), $sformatf("rand%0d_f%0d", i, f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
